// File: rtl/codec_pkg.sv
// Shared constants and types for the codec I2S interface: counter geometry,
// slot window, strobe phases and the stereo sample pair.
package codec_pkg;

  localparam int CNT_W    = 11;
  localparam int SAMPLE_W = 16;

  localparam int FIRST_SLOT = 1;
  localparam int LAST_SLOT  = 16;

  localparam logic [4:0]       RX_SAMPLE_PH = 5'h0F;
  localparam logic [4:0]       TX_SHIFT_PH  = 5'h1F;
  localparam logic [CNT_W-1:0] VALID_CNT    = 11'h610;

  typedef struct packed {
    logic [SAMPLE_W-1:0] left;
    logic [SAMPLE_W-1:0] right;
  } stereo_smpl_t;

  // Slot numbers are 6 bits wide so the "next slot" after 31 (i.e. 32) stays out of the window.
  function automatic logic slot_active(input logic [5:0] slot);
    return (slot >= 6'(FIRST_SLOT)) && (slot <= 6'(LAST_SLOT));
  endfunction

endpackage

// File: rtl/codec_clk_gen.sv
// Free-running 11-bit frame counter with registered MCLK/SCLK/LRCLK and the
// per-slot receive/transmit strobes used by the shift logic in the top.
module codec_clk_gen
  import codec_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  output logic [CNT_W-1:0] cnt,
  output logic             MCLK,
  output logic             SCLK,
  output logic             LRCLK,
  output logic             rx_strobe,
  output logic             tx_strobe,
  output logic             frame_wrap
);

  logic [CNT_W-1:0] cnt_nxt;

  assign cnt_nxt = cnt + CNT_W'(1);

  // Clocks are taken from the next count so each one equals its counter bit in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      MCLK  <= 1'b0;
      SCLK  <= 1'b0;
      LRCLK <= 1'b0;
    end else begin
      cnt   <= cnt_nxt;
      MCLK  <= cnt_nxt[1];
      SCLK  <= cnt_nxt[4];
      LRCLK <= cnt_nxt[10];
    end
  end

  assign rx_strobe  = (cnt[4:0] == RX_SAMPLE_PH);
  assign tx_strobe  = (cnt[4:0] == TX_SHIFT_PH);
  assign frame_wrap = &cnt;

endmodule

// File: rtl/codec_i2s_intf.sv
// Codec-side I2S sample interface: clock generation, ADC deserialiser and DAC serialiser.
// Build option CODEC_LOOPBACK_EN feeds the receive path from the internal SDin register.
module codec_i2s_intf
  import codec_pkg::*;
#(
  parameter int SKIP_FRAMES = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                SDout,
  input  logic [SAMPLE_W-1:0] lft_out,
  input  logic [SAMPLE_W-1:0] rht_out,
  output logic [SAMPLE_W-1:0] lft_in,
  output logic [SAMPLE_W-1:0] rht_in,
  output logic                valid,
  output logic                MCLK,
  output logic                SCLK,
  output logic                LRCLK,
  output logic                SDin
);

  localparam int SKIP_W = $clog2(SKIP_FRAMES + 1) + 1;

  logic [CNT_W-1:0]    cnt;
  logic                rx_strobe;
  logic                tx_strobe;
  logic                frame_wrap;
  logic [4:0]          slot;
  logic [5:0]          nxt_slot;
  logic [3:0]          tx_idx;
  logic                rx_active;
  logic                tx_active;
  logic                rx_bit;
  logic                word_done;
  logic                armed;
  logic [SKIP_W-1:0]   skip_cnt;
  logic [SAMPLE_W-1:0] tx_word;
  stereo_smpl_t        rx_shift;
  stereo_smpl_t        tx_hold;

  codec_clk_gen u_clk_gen (
    .clk        (clk),
    .rst_n      (rst_n),
    .cnt        (cnt),
    .MCLK       (MCLK),
    .SCLK       (SCLK),
    .LRCLK      (LRCLK),
    .rx_strobe  (rx_strobe),
    .tx_strobe  (tx_strobe),
    .frame_wrap (frame_wrap)
  );

  assign slot      = cnt[9:5];
  assign nxt_slot  = {1'b0, slot} + 6'd1;
  assign rx_active = slot_active({1'b0, slot});
  assign tx_active = slot_active(nxt_slot);
  assign tx_idx    = 4'(6'(LAST_SLOT) - nxt_slot);
  assign tx_word   = cnt[10] ? tx_hold.right : tx_hold.left;
  assign word_done = (cnt == VALID_CNT - CNT_W'(1));
  assign armed     = (skip_cnt >= SKIP_W'(SKIP_FRAMES));

`ifdef CODEC_LOOPBACK_EN
  assign rx_bit = SDin;
`else
  assign rx_bit = SDout;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_shift <= '0;
    end else if (rx_strobe && rx_active) begin
      if (cnt[10]) rx_shift.right <= {rx_shift.right[SAMPLE_W-2:0], rx_bit};
      else         rx_shift.left  <= {rx_shift.left[SAMPLE_W-2:0], rx_bit};
    end
  end

  // The right LSB is still arriving on the completing edge, so it is merged in directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lft_in <= '0;
      rht_in <= '0;
      valid  <= 1'b0;
    end else begin
      valid <= word_done && armed;
      if (word_done && armed) begin
        lft_in <= rx_shift.left;
        rht_in <= {rx_shift.right[SAMPLE_W-2:0], rx_bit};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  skip_cnt <= '0;
    else if (frame_wrap && !armed) skip_cnt <= skip_cnt + SKIP_W'(1);
  end

  // Capture happens after the last data bit of the frame has gone out, so no double buffer is needed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     tx_hold <= '0;
    else if (valid) tx_hold <= '{left: lft_out, right: rht_out};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         SDin <= 1'b0;
    else if (tx_strobe) SDin <= tx_active ? tx_word[tx_idx] : 1'b0;
  end

endmodule

// File: tb/tb_codec_i2s_intf.sv
// Self-checking bench for codec_i2s_intf: randomized codec/core traffic against a
// frame-level reference model, including a mid-frame reset.
module tb_codec_i2s_intf;

  localparam int SKIP  = 1;
  localparam int FRAME = 2048;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        SDout = 1'b0;
  logic [15:0] lft_out = '0;
  logic [15:0] rht_out = '0;
  logic [15:0] lft_in;
  logic [15:0] rht_in;
  logic        valid;
  logic        MCLK;
  logic        SCLK;
  logic        LRCLK;
  logic        SDin;

  int checks   = 0;
  int failures = 0;
  int abs_cnt  = 0;
  bit first_run = 1'b1;

  logic [15:0] rx_l = '0, rx_r = '0;
  logic [15:0] tx_cur_l = '0, tx_cur_r = '0;
  logic [15:0] tx_nxt_l = '0, tx_nxt_r = '0;
  logic [15:0] exp_lft = '0, exp_rht = '0;

  codec_i2s_intf #(.SKIP_FRAMES(SKIP)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .SDout   (SDout),
    .lft_out (lft_out),
    .rht_out (rht_out),
    .lft_in  (lft_in),
    .rht_in  (rht_in),
    .valid   (valid),
    .MCLK    (MCLK),
    .SCLK    (SCLK),
    .LRCLK   (LRCLK),
    .SDin    (SDin)
  );

  always #5 clk = ~clk;

  // Bench-side time base: clocks since reset release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) abs_cnt <= 0;
    else        abs_cnt <= abs_cnt + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      if (failures <= 50)
        $display("[TB] FAIL %s observed=%0h expected=%0h t=%0t", tag, observed, expected, $time);
    end
  endtask

  task automatic pickRxWords(input int frame);
    if (first_run && frame < 2) begin
      rx_l = 16'h8001;
      rx_r = 16'h7FFE;
    end else begin
      rx_l = 16'($urandom);
      rx_r = 16'($urandom);
    end
  endtask

  // Codec ADC model (MSB in slot 1) plus core samples that change every clock.
  task automatic applyStimulus(input int phase, input int frame);
    int slot = (phase / 32) % 32;
    logic [15:0] w;
    w = (phase >= 1024) ? rx_r : rx_l;
`ifdef CODEC_LOOPBACK_EN
    SDout = 1'($urandom);
`else
    if (slot >= 1 && slot <= 16) SDout = w[16 - slot];
    else                         SDout = 1'($urandom);
`endif
    lft_out = 16'($urandom);
    rht_out = 16'($urandom);
    if (first_run && frame == 1 && phase == 'h610) begin
`ifdef CODEC_LOOPBACK_EN
      lft_out = 16'h1234;
      rht_out = 16'hABCD;
`else
      lft_out = 16'hA5C3;
      rht_out = 16'h3C5A;
`endif
    end
  endtask

  always @(negedge clk) begin
    int phase;
    int frame;
    int slot;
    bit half;
    bit exp_valid;
    logic [15:0] w;
    logic exp_sd;
    phase = abs_cnt % FRAME;
    frame = abs_cnt / FRAME;
    slot  = (phase / 32) % 32;
    half  = (phase >= 1024);
    if (!rst_n) begin
      checkOutput("rst_lft_in", 32'(lft_in), 32'h0);
      checkOutput("rst_rht_in", 32'(rht_in), 32'h0);
      checkOutput("rst_valid",  32'(valid),  32'h0);
      checkOutput("rst_clocks", {29'h0, MCLK, SCLK, LRCLK}, 32'h0);
      checkOutput("rst_SDin",   32'(SDin),   32'h0);
      tx_cur_l = '0; tx_cur_r = '0;
      tx_nxt_l = '0; tx_nxt_r = '0;
      exp_lft  = '0; exp_rht  = '0;
      pickRxWords(0);
      applyStimulus(0, 0);
    end else begin
      if (phase == 0) begin
        tx_cur_l = tx_nxt_l;
        tx_cur_r = tx_nxt_r;
        pickRxWords(frame);
      end
      exp_valid = (phase == 'h610) && (frame >= SKIP);
      if (exp_valid) begin
`ifdef CODEC_LOOPBACK_EN
        exp_lft = tx_cur_l;
        exp_rht = tx_cur_r;
`else
        exp_lft = rx_l;
        exp_rht = rx_r;
`endif
      end
      checkOutput("valid",  32'(valid),  32'(exp_valid));
      checkOutput("lft_in", 32'(lft_in), 32'(exp_lft));
      checkOutput("rht_in", 32'(rht_in), 32'(exp_rht));
      checkOutput("MCLK",   32'(MCLK),   32'((phase / 2) % 2));
      checkOutput("SCLK",   32'(SCLK),   32'((phase / 16) % 2));
      checkOutput("LRCLK",  32'(LRCLK),  32'(half));
      w = half ? tx_cur_r : tx_cur_l;
      exp_sd = (slot >= 1 && slot <= 16) ? w[16 - slot] : 1'b0;
      checkOutput("SDin", 32'(SDin), 32'(exp_sd));
      applyStimulus(phase, frame);
      if (exp_valid) begin
        tx_nxt_l = lft_out;
        tx_nxt_r = rht_out;
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b1;
    $display("[TB] reset released, running directed then random frames");

    repeat (3 * FRAME + 'h300) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_lft_in", 32'(lft_in), 32'h0);
    checkOutput("mid_rst_rht_in", 32'(rht_in), 32'h0);
    checkOutput("mid_rst_valid",  32'(valid),  32'h0);
    checkOutput("mid_rst_clocks", {29'h0, MCLK, SCLK, LRCLK}, 32'h0);
    checkOutput("mid_rst_SDin",   32'(SDin),   32'h0);
    first_run = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    $display("[TB] mid-frame reset released, streaming random frames");

    repeat (10 * FRAME + 'h700) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
